// File: rtl/alu_pkg.sv
// Shared ALU opcode set and status flag bundle used by the ALU core and its pipeline wrapper.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA
  } Op;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } Flags;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: (op, a, b) -> (x, flags), zero latency, no handshake.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  Op                i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_x,
  output Flags             o_flags
);

  localparam int               MSB   = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_sra;
  logic             w_big;

  always_comb begin
    w_sum   = {1'b0, i_a} + {1'b0, i_b};
    w_diff  = {1'b0, i_a} - {1'b0, i_b};
    // Kept outside the case so the signed shift is not demoted by an unsigned ?: partner.
    w_sra   = $signed(i_a) >>> i_b;
    w_big   = (i_b >= W_LIM);
    o_x     = '0;
    o_flags = '0;
    case (i_op)
      ADD: begin
        o_x              = w_sum[MSB:0];
        o_flags.carry    = w_sum[WIDTH];
        o_flags.overflow = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      SUB: begin
        o_x              = w_diff[MSB:0];
        o_flags.carry    = w_diff[WIDTH];
        o_flags.overflow = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      AND:     o_x = i_a & i_b;
      OR:      o_x = i_a | i_b;
      XOR:     o_x = i_a ^ i_b;
      SLT:     o_x = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      SLTU:    o_x = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      SLL:     o_x = w_big ? '0 : (i_a << i_b);
      SRL:     o_x = w_big ? '0 : (i_a >> i_b);
      SRA:     o_x = w_big ? {WIDTH{i_a[MSB]}} : w_sra;
      default: o_x = '0;
    endcase
    o_flags.zero = (o_x == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU, LATENCY elastic stages (result visible LATENCY edges after accept).
// in_ready ripples combinationally back from out_ready; empty stages fill while downstream stalls.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  Op                in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [TAG_W-1:0] out_tag,
  output Flags             out_flags
);

  logic [WIDTH-1:0]   w_x;
  Flags               w_flags;
  logic [LATENCY-1:0] w_load;

  logic [LATENCY-1:0] r_vld;
  logic [WIDTH-1:0]   r_x     [LATENCY];
  Flags               r_flags [LATENCY];
  logic [TAG_W-1:0]   r_tag   [LATENCY];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op    (in_op),
    .i_a     (in_a),
    .i_b     (in_b),
    .o_x     (w_x),
    .o_flags (w_flags)
  );

  // A stage may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    w_load              = '0;
    w_load[LATENCY-1]   = ~r_vld[LATENCY-1] | out_ready;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      w_load[k] = ~r_vld[k] | w_load[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_x[k]     <= '0;
        r_flags[k] <= '0;
        r_tag[k]   <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_x[0]     <= w_x;
          r_flags[0] <= w_flags;
          r_tag[0]   <= in_tag;
        end
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_x[k]     <= r_x[k-1];
            r_flags[k] <= r_flags[k-1];
            r_tag[k]   <= r_tag[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_vld[LATENCY-1];
  assign out_x     = r_x[LATENCY-1];
  assign out_flags = r_flags[LATENCY-1];
  assign out_tag   = r_tag[LATENCY-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at three width/latency points against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready;
  Op    v8_in_op;
  logic [7:0] v8_in_a, v8_in_b, v8_out_x;
  logic [3:0] v8_in_tag, v8_out_tag;
  Flags v8_out_flags;

  logic v16_in_valid, v16_in_ready, v16_out_valid, v16_out_ready;
  Op    v16_in_op;
  logic [15:0] v16_in_a, v16_in_b, v16_out_x;
  logic [3:0]  v16_in_tag, v16_out_tag;
  Flags v16_out_flags;

  logic v32_in_valid, v32_in_ready, v32_out_valid, v32_out_ready;
  Op    v32_in_op;
  logic [31:0] v32_in_a, v32_in_b, v32_out_x;
  logic [3:0]  v32_in_tag, v32_out_tag;
  Flags v32_out_flags;

  alu_pipe #(.WIDTH(8), .LATENCY(3), .TAG_W(4)) u_pipe8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_op(v8_in_op),
    .in_a(v8_in_a), .in_b(v8_in_b), .in_tag(v8_in_tag),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_x(v8_out_x),
    .out_tag(v8_out_tag), .out_flags(v8_out_flags)
  );

  alu_pipe #(.WIDTH(16), .LATENCY(1), .TAG_W(4)) u_pipe16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16_in_valid), .in_ready(v16_in_ready), .in_op(v16_in_op),
    .in_a(v16_in_a), .in_b(v16_in_b), .in_tag(v16_in_tag),
    .out_valid(v16_out_valid), .out_ready(v16_out_ready), .out_x(v16_out_x),
    .out_tag(v16_out_tag), .out_flags(v16_out_flags)
  );

  alu_pipe #(.WIDTH(32), .LATENCY(4), .TAG_W(4)) u_pipe32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v32_in_valid), .in_ready(v32_in_ready), .in_op(v32_in_op),
    .in_a(v32_in_a), .in_b(v32_in_b), .in_tag(v32_in_tag),
    .out_valid(v32_out_valid), .out_ready(v32_out_ready), .out_x(v32_out_x),
    .out_tag(v32_out_tag), .out_flags(v32_out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [2:0]  f;
    logic [3:0]  tag;
  } exp_t;

  // Reference: interpret operands as integers of width w and apply the textbook definitions.
  function automatic exp_t model(int w, Op op, logic [31:0] a, logic [31:0] b, logic [3:0] tag);
    exp_t   e;
    longint mask, half, ua, ub, sa, sb, r, s;
    logic   c, v;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      ADD:  begin r = ua + ub; c = (r > mask); s = sa + sb; v = (s >= half) || (s < -half); end
      SUB:  begin r = ua - ub; c = (ua < ub);  s = sa - sb; v = (s >= half) || (s < -half); end
      AND:  r = ua & ub;
      OR:   r = ua | ub;
      XOR:  r = ua ^ ub;
      SLT:  r = (sa < sb) ? 1 : 0;
      SLTU: r = (ua < ub) ? 1 : 0;
      SLL:  r = (ub >= w) ? 0 : (ua << ub);
      SRL:  r = (ub >= w) ? 0 : (ua >> ub);
      SRA:  r = (ub >= w) ? ((sa < 0) ? mask : 0) : (sa >>> ub);
      default: r = 0;
    endcase
    r     = r & mask;
    e.x   = 32'(r);
    e.f   = {(r == 0), c, v};
    e.tag = tag;
    return e;
  endfunction

  function automatic logic [31:0] rnd_val(int w);
    longint mask;
    mask = (longint'(1) << w) - 1;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'(mask);
      2: return 32'(longint'(1) << (w - 1));
      3: return 32'((longint'(1) << (w - 1)) - 1);
      4: return 32'($urandom_range(0, w + 2));
      default: return 32'({32'd0, $urandom()} & mask);
    endcase
  endfunction

  task automatic test_reset();
    #3;
    n_checks++;
    if ({v8_out_valid, v16_out_valid, v32_out_valid} !== 3'b000) begin
      n_errors++; $display("FAIL reset_valid: got %b expected 000", {v8_out_valid, v16_out_valid, v32_out_valid});
    end
    n_checks++;
    if ({v8_out_x, v8_out_tag, v8_out_flags} !== 15'd0) begin
      n_errors++; $display("FAIL reset_fields: got %h expected 0", {v8_out_x, v8_out_tag, v8_out_flags});
    end
    n_checks++;
    if ({v32_out_x, v32_out_tag, v32_out_flags} !== 39'd0) begin
      n_errors++; $display("FAIL reset_fields32: got %h expected 0", {v32_out_x, v32_out_tag, v32_out_flags});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({v8_in_ready, v16_in_ready, v32_in_ready} !== 3'b111) begin
      n_errors++; $display("FAIL reset_in_ready: got %b expected 111", {v8_in_ready, v16_in_ready, v32_in_ready});
    end
  endtask

  task automatic test_directed();
    Op          ops[16] = '{ADD, SUB, SUB, SLT, SLTU, SRA, SLL, SRL, ADD, AND, OR, XOR, SLL, SRA, SRA, SRL};
    logic [7:0] as[16]  = '{8'hFF, 8'h80, 8'h01, 8'h80, 8'h80, 8'h80, 8'h01, 8'h80,
                            8'h7F, 8'hF0, 8'h00, 8'hAA, 8'h01, 8'h80, 8'h40, 8'h80};
    logic [7:0] bs[16]  = '{8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h09, 8'h08, 8'h07,
                            8'h01, 8'h3C, 8'h00, 8'h55, 8'h07, 8'h07, 8'h09, 8'h08};
    logic [7:0] xs[16]  = '{8'h00, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h01,
                            8'h80, 8'h30, 8'h00, 8'hFF, 8'h80, 8'hFF, 8'h00, 8'h00};
    logic [2:0] fs[16]  = '{3'b110, 3'b001, 3'b010, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000,
                            3'b001, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100};
    int   lat;
    logic got;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      v8_out_ready = 1'b1;
      v8_in_valid  = 1'b1;
      v8_in_op     = ops[i];
      v8_in_a      = as[i];
      v8_in_b      = bs[i];
      v8_in_tag    = 4'(i);
      @(negedge clk);
      n_checks++;
      if (v8_in_ready !== 1'b1) begin
        n_errors++; $display("FAIL dir_in_ready[%0d]: got %b expected 1", i, v8_in_ready);
      end
      @(posedge clk); #1;
      v8_in_valid = 1'b0;
      lat = 1;
      got = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (v8_out_valid === 1'b1) begin got = 1'b1; break; end
        @(posedge clk);
        lat++;
      end
      n_checks++;
      if (!got || lat != 3) begin
        n_errors++; $display("FAIL dir_latency[%0d]: got %0d (seen=%b) expected 3", i, lat, got);
      end
      n_checks++;
      if (v8_out_x !== xs[i]) begin
        n_errors++; $display("FAIL dir_x[%0d] op=%s: got %h expected %h", i, ops[i].name(), v8_out_x, xs[i]);
      end
      n_checks++;
      if (v8_out_flags !== fs[i]) begin
        n_errors++; $display("FAIL dir_flags[%0d] op=%s: got %b expected %b", i, ops[i].name(), v8_out_flags, fs[i]);
      end
      n_checks++;
      if (v8_out_tag !== 4'(i)) begin
        n_errors++; $display("FAIL dir_tag[%0d]: got %h expected %h", i, v8_out_tag, 4'(i));
      end
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    int          next = 0;
    logic [15:0] snap;
    @(posedge clk); #1;
    v8_out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      v8_in_valid = (next < 5);
      v8_in_op    = ADD;
      v8_in_a     = 8'(next);
      v8_in_b     = 8'd1;
      v8_in_tag   = 4'(next);
      @(negedge clk);
      if (v8_in_valid && v8_in_ready) next++;
    end
    n_checks++;
    if (next != 3) begin
      n_errors++; $display("FAIL bp_accepted: got %0d expected 3", next);
    end
    n_checks++;
    if ({v8_out_valid, v8_out_tag, v8_out_x} !== {1'b1, 4'd0, 8'd1}) begin
      n_errors++; $display("FAIL bp_head: got %h expected %h", {v8_out_valid, v8_out_tag, v8_out_x}, {1'b1, 4'd0, 8'd1});
    end
    snap = {v8_out_valid, v8_out_x, v8_out_tag, v8_out_flags};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({v8_in_ready, v8_out_valid, v8_out_x, v8_out_tag, v8_out_flags} !== {1'b0, snap}) begin
        n_errors++; $display("FAIL bp_stable[%0d]: got %h expected %h", c,
                             {v8_in_ready, v8_out_valid, v8_out_x, v8_out_tag, v8_out_flags}, {1'b0, snap});
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      v8_out_ready = 1'b1;
      v8_in_valid  = (next < 5);
      v8_in_a      = 8'(next);
      v8_in_tag    = 4'(next);
      @(negedge clk);
      n_checks++;
      if ({v8_out_valid, v8_out_tag, v8_out_x} !== {1'b1, 4'(c), 8'(c + 1)}) begin
        n_errors++; $display("FAIL bp_drain[%0d]: got %h expected %h", c,
                             {v8_out_valid, v8_out_tag, v8_out_x}, {1'b1, 4'(c), 8'(c + 1)});
      end
      if (v8_in_valid && v8_in_ready) next++;
    end
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (v8_out_valid !== 1'b0) begin
      n_errors++; $display("FAIL bp_empty: got %b expected 0", v8_out_valid);
    end
  endtask

  task automatic test_throughput();
    exp_t q[$];
    exp_t e;
    int   sent = 0, recv = 0, first = -1, last = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      v8_out_ready = 1'b1;
      v8_in_valid  = (sent < 20);
      v8_in_op     = Op'($urandom_range(0, 9));
      v8_in_a      = 8'(rnd_val(8));
      v8_in_b      = 8'(rnd_val(8));
      v8_in_tag    = 4'($urandom());
      @(negedge clk);
      if (v8_out_valid) begin
        if (first < 0) first = c;
        last = c;
        recv++;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++; $display("FAIL tp_unexpected: got output tag %h expected none", v8_out_tag);
        end else begin
          e = q.pop_front();
          if ({v8_out_x, v8_out_flags, v8_out_tag} !== {e.x[7:0], e.f, e.tag}) begin
            n_errors++; $display("FAIL tp_result: got x=%h f=%b t=%h expected x=%h f=%b t=%h",
                                 v8_out_x, v8_out_flags, v8_out_tag, e.x[7:0], e.f, e.tag);
          end
        end
      end
      if (v8_in_valid && v8_in_ready) begin
        q.push_back(model(8, v8_in_op, {24'd0, v8_in_a}, {24'd0, v8_in_b}, v8_in_tag));
        sent++;
      end
    end
    n_checks++;
    if (sent != 20 || recv != 20 || (last - first) != 19) begin
      n_errors++; $display("FAIL tp_rate: got sent=%0d recv=%0d span=%0d expected 20 20 19", sent, recv, last - first);
    end
  endtask

  task automatic test_reset_midstream();
    int   emitted = 0;
    int   lat;
    logic got;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      v8_out_ready = 1'b0;
      v8_in_valid  = 1'b1;
      v8_in_op     = XOR;
      v8_in_a      = 8'h5A;
      v8_in_b      = 8'(c);
      v8_in_tag    = 4'(c + 1);
    end
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (v8_out_valid !== 1'b1) begin
      n_errors++; $display("FAIL rst_pre_valid: got %b expected 1", v8_out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({v8_out_valid, v8_out_x, v8_out_tag, v8_out_flags} !== 16'd0) begin
      n_errors++; $display("FAIL rst_async: got %h expected 0", {v8_out_valid, v8_out_x, v8_out_tag, v8_out_flags});
    end
    @(posedge clk); #1;
    rst_n        = 1'b1;
    v8_out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (v8_out_valid === 1'b1) emitted++;
    end
    n_checks++;
    if (emitted != 0) begin
      n_errors++; $display("FAIL rst_ghost: got %0d outputs expected 0", emitted);
    end
    @(posedge clk); #1;
    v8_in_valid = 1'b1;
    v8_in_op    = ADD;
    v8_in_a     = 8'h12;
    v8_in_b     = 8'h34;
    v8_in_tag   = 4'h9;
    @(posedge clk); #1;
    v8_in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (v8_out_valid === 1'b1) begin got = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    n_checks++;
    if (!got || lat != 3 || {v8_out_x, v8_out_tag} !== {8'h46, 4'h9}) begin
      n_errors++; $display("FAIL rst_after: got lat=%0d seen=%b x=%h t=%h expected lat=3 x=46 t=9",
                           lat, got, v8_out_x, v8_out_tag);
    end
    @(posedge clk);
  endtask

  task automatic test_regress16();
    exp_t        q[$];
    exp_t        e;
    int          sent = 0, recv = 0;
    logic        stall = 1'b0;
    logic [23:0] snap = '0;
    for (int c = 0; c < 3000 && recv < 200; c++) begin
      @(posedge clk); #1;
      v16_in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      v16_out_ready = ($urandom_range(0, 3) != 0);
      v16_in_op     = Op'($urandom_range(0, 9));
      v16_in_a      = 16'(rnd_val(16));
      v16_in_b      = 16'(rnd_val(16));
      v16_in_tag    = 4'($urandom());
      @(negedge clk);
      if (stall) begin
        n_checks++;
        if ({v16_out_valid, v16_out_x, v16_out_tag, v16_out_flags} !== snap) begin
          n_errors++; $display("FAIL r16_stable: got %h expected %h",
                               {v16_out_valid, v16_out_x, v16_out_tag, v16_out_flags}, snap);
        end
      end
      if (v16_out_valid && v16_out_ready) begin
        recv++;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++; $display("FAIL r16_unexpected: got output tag %h expected none", v16_out_tag);
        end else begin
          e = q.pop_front();
          if ({v16_out_x, v16_out_flags, v16_out_tag} !== {e.x[15:0], e.f, e.tag}) begin
            n_errors++; $display("FAIL r16_result: got x=%h f=%b t=%h expected x=%h f=%b t=%h",
                                 v16_out_x, v16_out_flags, v16_out_tag, e.x[15:0], e.f, e.tag);
          end
        end
      end
      if (v16_in_valid && v16_in_ready) begin
        q.push_back(model(16, v16_in_op, {16'd0, v16_in_a}, {16'd0, v16_in_b}, v16_in_tag));
        sent++;
      end
      stall = v16_out_valid && !v16_out_ready;
      snap  = {v16_out_valid, v16_out_x, v16_out_tag, v16_out_flags};
    end
    n_checks++;
    if (recv != 200 || q.size() != 0) begin
      n_errors++; $display("FAIL r16_count: got recv=%0d pending=%0d expected 200 0", recv, q.size());
    end
    @(posedge clk); #1;
    v16_in_valid = 1'b0;
  endtask

  task automatic test_regress32();
    exp_t        q[$];
    exp_t        e;
    int          sent = 0, recv = 0;
    logic        stall = 1'b0;
    logic [39:0] snap = '0;
    for (int c = 0; c < 3000 && recv < 200; c++) begin
      @(posedge clk); #1;
      v32_in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      v32_out_ready = ($urandom_range(0, 2) != 0);
      v32_in_op     = Op'($urandom_range(0, 9));
      v32_in_a      = rnd_val(32);
      v32_in_b      = rnd_val(32);
      v32_in_tag    = 4'($urandom());
      @(negedge clk);
      if (stall) begin
        n_checks++;
        if ({v32_out_valid, v32_out_x, v32_out_tag, v32_out_flags} !== snap) begin
          n_errors++; $display("FAIL r32_stable: got %h expected %h",
                               {v32_out_valid, v32_out_x, v32_out_tag, v32_out_flags}, snap);
        end
      end
      if (v32_out_valid && v32_out_ready) begin
        recv++;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++; $display("FAIL r32_unexpected: got output tag %h expected none", v32_out_tag);
        end else begin
          e = q.pop_front();
          if ({v32_out_x, v32_out_flags, v32_out_tag} !== {e.x, e.f, e.tag}) begin
            n_errors++; $display("FAIL r32_result: got x=%h f=%b t=%h expected x=%h f=%b t=%h",
                                 v32_out_x, v32_out_flags, v32_out_tag, e.x, e.f, e.tag);
          end
        end
      end
      if (v32_in_valid && v32_in_ready) begin
        q.push_back(model(32, v32_in_op, v32_in_a, v32_in_b, v32_in_tag));
        sent++;
      end
      stall = v32_out_valid && !v32_out_ready;
      snap  = {v32_out_valid, v32_out_x, v32_out_tag, v32_out_flags};
    end
    n_checks++;
    if (recv != 200 || q.size() != 0) begin
      n_errors++; $display("FAIL r32_count: got recv=%0d pending=%0d expected 200 0", recv, q.size());
    end
    @(posedge clk); #1;
    v32_in_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    v8_in_valid   = 1'b0; v8_out_ready  = 1'b0; v8_in_op  = ADD; v8_in_a  = '0; v8_in_b  = '0; v8_in_tag  = '0;
    v16_in_valid  = 1'b0; v16_out_ready = 1'b0; v16_in_op = ADD; v16_in_a = '0; v16_in_b = '0; v16_in_tag = '0;
    v32_in_valid  = 1'b0; v32_out_ready = 1'b0; v32_in_op = ADD; v32_in_a = '0; v32_in_b = '0; v32_in_tag = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    test_regress16();
    test_regress32();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
